// File: rtl/fp_pkg.sv
// Shared definitions for the iterative binary32 multiplier.
// Holds IEEE-754 constants, the controller state encoding and small
// field-extract helpers used by the top and its testbench.
package fp_pkg;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPECIAL = 3'd1,
    CALC    = 3'd2,
    NORM    = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic get_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] get_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] get_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

  // Zero/denormal (0) and inf/NaN (255) exponents bypass the datapath.
  function automatic logic exp_special(input logic [7:0] e);
    return (e == 8'h00) || (e == EXP_MAX);
  endfunction

endpackage

// File: rtl/fp_mant_shiftadd.sv
// Radix-2 shift-add mantissa multiplier.
// A start pulse loads both mantissas and clears the accumulator; the
// next MANT_W cycles each add the (left-shifting) multiplicand when the
// (right-shifting) multiplier LSB is set.
// Ports:
//   clk, rst   clock, async active-high reset
//   start      load operands and begin (ignored while running is not
//              prevented; the controller only starts from idle)
//   mcand_in   multiplicand mantissa, hidden bit included
//   mplr_in    multiplier mantissa, hidden bit included
//   done       high during the final iteration; prod is complete after
//              that clock edge
//   prod       2*MANT_W-bit accumulator
module fp_mant_shiftadd #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MANT_W-1:0]     mcand_in,
  input  logic [MANT_W-1:0]     mplr_in,
  output logic                  done,
  output logic [2*MANT_W-1:0]   prod
);

  localparam int CNT_W = $clog2(MANT_W + 1);

  logic [2*MANT_W-1:0] mcand_q;
  logic [2*MANT_W-1:0] acc_q;
  logic [MANT_W-1:0]   mplr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy;

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));
  assign prod = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      mcand_q <= {{MANT_W{1'b0}}, mcand_in};
      acc_q   <= '0;
      mplr_q  <= mplr_in;
      cnt_q   <= CNT_W'(MANT_W);
    end else if (busy) begin
      if (mplr_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fp_mult_iter.sv
// Multi-cycle IEEE-754 binary32 multiplier (truncating, no denormals).
// Zero or denormal operands give +0; inf/NaN give signed infinity;
// 0 * inf gives a quiet NaN.
// Ports:
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    operand handshake (ready only when idle)
//   A, B                 binary32 operands
//   out_valid/out_ready  result handshake; result held until accepted
//   result               A*B, rounded toward zero
//   overflow             result saturated to infinity
//   underflow            nonzero product flushed to zero
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// SPECIAL | one cycle to form a zero/inf/NaN result
// CALC    | MANT_W shift-add iterations in fp_mant_shiftadd
// NORM    | normalise product, apply exponent limits
// DONE    | out_valid high until out_ready
module fp_mult_iter #(
  parameter int XLEN   = 32,
  parameter int MANT_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow
);

  import fp_pkg::*;

  state_t state_q, state_d;

  logic [7:0]          ea_q, eb_q;
  logic                sign_q;
  logic [XLEN-1:0]     result_q;
  logic                ovf_q, unf_q;
  logic                accept;
  logic                start;
  logic                mant_done;
  logic [2*MANT_W-1:0] prod;

  logic [9:0]          e_sum;
  logic signed [9:0]   e_adj;
  logic [22:0]         frac;
  logic [XLEN-1:0]     norm_res;
  logic                norm_ovf, norm_unf;
  logic [XLEN-1:0]     spec_res;
  logic                prod_unused;

  assign accept = in_valid && in_ready;

  fp_mant_shiftadd #(.MANT_W(MANT_W)) u_mant (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mcand_in ({1'b1, get_frac(A)}),
    .mplr_in  ({1'b1, get_frac(B)}),
    .done     (mant_done),
    .prod     (prod)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (exp_special(get_exp(A)) || exp_special(get_exp(B))) begin
            state_d = SPECIAL;
          end else begin
            state_d = CALC;
            start   = 1'b1;
          end
        end
      end
      SPECIAL: state_d = DONE;
      CALC:    if (mant_done) state_d = NORM;
      NORM:    state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Exponent kept in 10 bits so both overflow (>=255) and underflow (<=0)
  // are visible; the operand range keeps it within -125..382.
  always_comb begin
    e_sum    = {2'b00, ea_q} + {2'b00, eb_q} - 10'(BIAS);
    e_adj    = $signed(e_sum + {9'd0, prod[2*MANT_W-1]});
    frac     = prod[2*MANT_W-1] ? prod[2*MANT_W-2 -: 23] : prod[2*MANT_W-3 -: 23];
    norm_ovf = (e_adj >= 10'sd255);
    norm_unf = (e_adj <= 10'sd0);
    if (norm_ovf) begin
      norm_res = {sign_q, EXP_MAX, 23'h0};
    end else if (norm_unf) begin
      norm_res = '0;
    end else begin
      norm_res = {sign_q, e_adj[7:0], frac};
    end
  end

  // Truncation discards the low product bits.
  assign prod_unused = ^prod[MANT_W-2:0];

  always_comb begin
    if (((ea_q == 8'h00) && (eb_q == EXP_MAX)) ||
        ((eb_q == 8'h00) && (ea_q == EXP_MAX))) begin
      spec_res = QNAN;
    end else if ((ea_q == 8'h00) || (eb_q == 8'h00)) begin
      spec_res = '0;
    end else begin
      spec_res = {sign_q, EXP_MAX, 23'h0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ea_q     <= '0;
      eb_q     <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ea_q   <= get_exp(A);
        eb_q   <= get_exp(B);
        sign_q <= get_sign(A) ^ get_sign(B);
        ovf_q  <= 1'b0;
        unf_q  <= 1'b0;
      end
      if (state_q == SPECIAL) begin
        result_q <= spec_res;
      end
      if (state_q == NORM) begin
        result_q <= norm_res;
        ovf_q    <= norm_ovf;
        unf_q    <= norm_unf;
      end
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/fp_mult_iter.md
Name: fp_mult_iter

Overview:
- Multi-cycle IEEE-754 single-precision multiplier; the inverse operation of the cosine-similarity divider.
- Rebuilds the original quantity from a quotient and divisor, and forms the |A|·|B| denominator product.
- Uses a radix-2 shift-add mantissa datapath with valid/ready handshakes on both sides, trading latency for area.
- Zero/denormal conventions match the divider: a zero exponent means zero, and the result is forced to 32'h0.

Parameters:
- XLEN, 32, operand/result width; only 32 (binary32) is supported.
- MANT_W, 24, mantissa width including hidden bit; sets the iteration count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operands A, B valid
- in_ready  out  1  block idle, can accept operands
- A  in  XLEN  multiplicand
- B  in  XLEN  multiplier
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts result
- result  out  XLEN  A*B, truncated
- overflow  out  1  result saturated to infinity (qualified by out_valid)
- underflow  out  1  nonzero product flushed to zero (qualified by out_valid)

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, underflow=0, accumulator/counter cleared. Reset mid-operation aborts the operation with no output.
- Operand capture: A, B, sign=A[31]^B[31] latched on clk edge with in_valid&&in_ready.
- State machine:
  - IDLE, on accept, goes to SPECIAL if A[30:23] or B[30:23] is 0 or 255; otherwise to CALC.
  - SPECIAL takes 1 cycle, then DONE.
  - CALC runs MANT_W (24) cycles. Each cycle: if the multiplier LSB is 1, add the shifted multiplicand into a 48-bit accumulator; shift; decrement counter. Counter reaching 0 goes to NORM.
  - NORM takes 1 cycle, then DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE, same cycle.
- Latency, normal path: out_valid first high 26 cycles after the accept edge. Special path: 2 cycles.
- in_ready=1 only in IDLE; no new accept in the same cycle DONE hands off. Throughput is 1 op per 27 cycles minimum.
- Exponent arithmetic:
  - 10-bit signed e = Ea + Eb − 127.
  - If P[47]=1: frac=P[46:24], e=e+1. Else: frac=P[45:23].
  - Round toward zero (truncate); no sticky or guard bits.
- Overflow: e ≥ 255 gives result={sign,8'hFF,23'h0}, overflow=1.
- Underflow: e ≤ 0 gives result=32'h0, underflow=1. No denormal output.
- Special operands, in priority order:
  1. Either exponent 0 and other exponent 255 gives 32'h7FC00000.
  2. Either exponent 0 (zero or denormal) gives 32'h00000000 (unsigned zero, as the divider does).
  3. Either exponent 255 gives {sign,8'hFF,23'h0}. NaN payloads are not propagated; NaN is treated as infinity.
- Hold: result and flags are stable while out_valid=1 && out_ready=0. Input changes in non-IDLE states are ignored.
- Flags are cleared on each accept.

Decomposition:
- Shared package fp_pkg:
  - constants BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7FC00000
  - FSM state enum {IDLE, SPECIAL, CALC, NORM, DONE}
  - field-extract helpers for sign/exponent/fraction
- One natural sub-module: fp_mant_shiftadd, the 24×24 iterative mantissa multiplier with start/done, 48-bit product.
- Control, exponent path, normalisation and special cases stay in the top.

Test Plan:
- 0x3FC00000 × 0x40000000 (1.5×2.0) → result 0x40400000, flags 0, out_valid exactly 26 cycles after accept.
- 0xC0400000 × 0x3F000000 (−3.0×0.5) → 0xBFC00000. Also 0x3FFFFFFF × 0x3FFFFFFF → 0x407FFFFE (truncation check).
- 0x00000000 × 0x40490FDB → 0x00000000 after 2 cycles. 0x00000000 × 0x7F800000 → 0x7FC00000.
- 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1. 0x00800000 × 0x3F000000 → 0x00000000, underflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 → handoff, in_ready=1 next cycle.
- Assert rst at CALC cycle 10 → out_valid=0 and in_ready=1 immediately (async). Next operation 0x40400000 × 0x40400000 → 0x41100000 with the full 26-cycle latency.
